// File: rtl/logic_net_pipe.sv
// Bitwise four-mode gate network feeding a STAGES-deep valid/ready elastic pipeline,
// with a saturating count of set bits on x over all output transfers.
module logic_net_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] f_x, f_y;

    always_comb begin
        f_x = '0;
        f_y = '0;
        case (mode)
            2'b00: begin
                f_x = ~c ^ (a | b);
                f_y = (a | b) & (~(a & b) ^ (a | b));
            end
            2'b01: begin
                f_x = c ^ (a & b);
                f_y = a ^ b;
            end
            2'b10: begin
                f_x = (a & b) | (a & c) | (b & c);
                f_y = a ^ b ^ c;
            end
            default: begin
                f_x = a;
                f_y = b;
            end
        endcase
    end

    logic [STAGES-1:0]            v, v_nxt, ld;
    logic [STAGES-1:0][WIDTH-1:0] sx, sy, sx_nxt, sy_nxt;

    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_stage
        // A stage can load unless it and every stage below it are full while the sink stalls.
        assign ld[g] = out_ready || !(&v[STAGES-1:g]);

        if (g == 0) begin : g_head
            assign v_nxt[g]  = ld[g] ? in_valid : v[g];
            assign sx_nxt[g] = ld[g] ? f_x      : sx[g];
            assign sy_nxt[g] = ld[g] ? f_y      : sy[g];
        end else begin : g_body
            assign v_nxt[g]  = ld[g] ? v[g-1]  : v[g];
            assign sx_nxt[g] = ld[g] ? sx[g-1] : sx[g];
            assign sy_nxt[g] = ld[g] ? sy[g-1] : sy[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v  <= '0;
            sx <= '0;
            sy <= '0;
        end else begin
            v  <= v_nxt;
            sx <= sx_nxt;
            sy <= sy_nxt;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[STAGES-1];
    assign x         = sx[STAGES-1];
    assign y         = sy[STAGES-1];

    logic             out_xfer;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] base, sum;
    logic [CNT_W-1:0] cnt_sat;

    assign out_xfer = out_valid && out_ready;

    // A clear coinciding with a transfer restarts the count from this beat's ones.
    always_comb begin
        pc      = PC_W'($countones(x));
        base    = clr_cnt ? '0 : SUM_W'(ones_cnt);
        sum     = base + SUM_W'(pc);
        cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (out_xfer) begin
            ones_cnt <= cnt_sat;
        end else if (clr_cnt) begin
            ones_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_logic_net_pipe.sv
// Directed bench for logic_net_pipe: a default instance plus a CNT_W=4 instance sharing stimulus.
module tb_logic_net_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, clr_cnt;
    logic [7:0] a, b, c;
    logic [1:0] mode;
    logic       in_ready, out_valid, in_ready_s, out_valid_s;
    logic [7:0] x, y, x_s, y_s;
    logic [15:0] ones_cnt;
    logic [3:0]  ones_s;

    always #5 clk = ~clk;

    logic_net_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .clr_cnt(clr_cnt), .ones_cnt(ones_cnt)
    );

    logic_net_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .c(c), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
        .x(x_s), .y(y_s), .clr_cnt(clr_cnt), .ones_cnt(ones_s)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a, b, c;
        logic [7:0] ex, ey;
    } vec_t;

    vec_t vt [4];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt, exp_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        mode     = v.mode;
        a        = v.a;
        b        = v.b;
        c        = v.c;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a = '0; b = '0; c = '0; mode = '0;
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                                input logic [7:0] vc, input logic [7:0] ex, input logic [7:0] ey);
        vec_t r;
        r.mode = m; r.a = va; r.b = vb; r.c = vc; r.ex = ex; r.ey = ey;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0] = mk(2'b00, 8'hF0, 8'hCC, 8'hAA, 8'hA9, 8'hC0);
        vt[1] = mk(2'b01, 8'hF0, 8'hCC, 8'hAA, 8'h6A, 8'h3C);
        vt[2] = mk(2'b10, 8'hF0, 8'hCC, 8'hAA, 8'hE8, 8'h96);
        vt[3] = mk(2'b11, 8'hF0, 8'hCC, 8'hAA, 8'hF0, 8'hCC);

        rst_n = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_cnt", 32'(ones_cnt), 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);

        // Single beats through each mode: latency, results, cumulative count.
        exp_cnt = 0; exp_s = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_in_ready", 32'(in_ready), 1);
            drive(vt[i]);
            @(negedge clk);
            idle();
            chk("single_lat1_valid", 32'(out_valid), 0);
            @(negedge clk);
            chk("single_lat2_valid", 32'(out_valid), 1);
            chk("single_x", 32'(x), 32'(vt[i].ex));
            chk("single_y", 32'(y), 32'(vt[i].ey));
            exp_cnt += $countones(vt[i].ex);
            exp_s = (exp_s + $countones(vt[i].ex) > 15) ? 15 : exp_s + $countones(vt[i].ex);
            @(negedge clk);
            chk("single_drain_valid", 32'(out_valid), 0);
            chk("single_cnt", 32'(ones_cnt), 32'(exp_cnt));
            chk("single_cnt_sat", 32'(ones_s), 32'(exp_s));
        end

        // clr_cnt with no transfer.
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(ones_cnt), 0);
        chk("clr_cnt_sat", 32'(ones_s), 0);

        // Back-to-back four beats.
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc < 6) begin
                chk("b2b_valid", 32'(out_valid), 1);
                chk("b2b_x", 32'(x), 32'(vt[cyc-2].ex));
                chk("b2b_y", 32'(y), 32'(vt[cyc-2].ey));
            end else begin
                chk("b2b_idle_valid", 32'(out_valid), 0);
            end
            if (cyc < 4) begin
                chk("b2b_in_ready", 32'(in_ready), 1);
                drive(vt[cyc]);
            end else begin
                idle();
            end
        end
        chk("b2b_cnt", 32'(ones_cnt), 16);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;

        // Stall: three beats against a blocked sink.
        out_ready = 1'b0;
        chk("stall_in_ready0", 32'(in_ready), 1);
        drive(vt[0]);
        @(negedge clk);
        chk("stall_in_ready1", 32'(in_ready), 1);
        drive(vt[1]);
        @(negedge clk);
        drive(vt[2]);
        #1;
        chk("stall_full_in_ready", 32'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_x", 32'(x), 32'(vt[0].ex));
            chk("stall_y", 32'(y), 32'(vt[0].ey));
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_cnt_hold", 32'(ones_cnt), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("stall_release_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        idle();
        chk("stall_out1_x", 32'(x), 32'(vt[1].ex));
        chk("stall_out1_valid", 32'(out_valid), 1);
        chk("stall_full_xfer_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("stall_out2_x", 32'(x), 32'(vt[2].ex));
        chk("stall_out2_y", 32'(y), 32'(vt[2].ey));
        @(negedge clk);
        chk("stall_drained", 32'(out_valid), 0);
        chk("stall_cnt", 32'(ones_cnt), 12);

        // Saturation on the CNT_W=4 instance, then clear coinciding with a transfer.
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 3) begin
                chk("sat_cnt8", 32'(ones_s), 8);
                chk("sat_wide_cnt8", 32'(ones_cnt), 8);
            end
            if (cyc == 4) begin
                chk("sat_cnt15", 32'(ones_s), 15);
                chk("sat_wide_cnt16", 32'(ones_cnt), 16);
            end
            if (cyc == 5) begin
                chk("sat_cnt_stay15", 32'(ones_s), 15);
                chk("sat_wide_cnt24", 32'(ones_cnt), 24);
            end
            if (cyc < 3) drive(mk(2'b11, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00));
            else if (cyc == 5) drive(mk(2'b11, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00));
            else idle();
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        chk("clrx_valid", 32'(out_valid_s), 1);
        chk("clrx_x", 32'(x_s), 32'h0F);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clrx_cnt_sat", 32'(ones_s), 4);
        chk("clrx_cnt", 32'(ones_cnt), 4);

        // Asynchronous reset with two beats in flight.
        drive(vt[0]);
        @(negedge clk);
        drive(vt[1]);
        @(negedge clk);
        idle();
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_x", 32'(x), 0);
        chk("arst_y", 32'(y), 0);
        chk("arst_cnt", 32'(ones_cnt), 0);
        chk("arst_cnt_sat", 32'(ones_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_stale", 32'(out_valid), 0);
        end
        chk("arst_cnt_after", 32'(ones_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
